// File: rtl/pipeline_pkg.sv
// Shared MIPS pipeline definitions: instruction field positions, PC step and the IF/ID payload.
package pipeline_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned RS_MSB = 25;
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_MSB = 20;
  localparam int unsigned RT_LSB = 16;

  typedef logic [XLEN-1:0]  word_t;
  typedef logic [REG_W-1:0] reg_idx_t;

  localparam word_t NOP_INSTR = 32'h0000_0000;
  localparam word_t PC_STEP   = 32'd4;

  typedef struct packed {
    word_t instr;
    word_t pc_add4;
    logic  valid;
  } if_id_t;

  function automatic reg_idx_t rs_field(input word_t instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic reg_idx_t rt_field(input word_t instr);
    return instr[RT_MSB:RT_LSB];
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch/decode boundary signals: imem, ID-resolved control flow, EX load info and ID/EX controls.
interface if_id_stage_if;

  logic                     hold;
  pipeline_pkg::word_t      instructionIF;
  logic                     branchTakenID;
  pipeline_pkg::word_t      branchTargetID;
  logic                     jumpID;
  pipeline_pkg::word_t      jumpTargetID;
  logic                     memReadEX;
  pipeline_pkg::reg_idx_t   instructionRtEX;
  pipeline_pkg::word_t      pcIF;
  pipeline_pkg::word_t      pcAdd4ID;
  pipeline_pkg::word_t      instructionID;
  logic                     validID;
  logic                     idExFlush;
  logic                     idExStall;

  modport master (
    input  hold, instructionIF, branchTakenID, branchTargetID, jumpID, jumpTargetID,
           memReadEX, instructionRtEX,
    output pcIF, pcAdd4ID, instructionID, validID, idExFlush, idExStall
  );

  modport slave (
    output hold, instructionIF, branchTakenID, branchTargetID, jumpID, jumpTargetID,
           memReadEX, instructionRtEX,
    input  pcIF, pcAdd4ID, instructionID, validID, idExFlush, idExStall
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard detector: a load in EX whose rt feeds either source of the instruction in ID.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic     valid_id_i,
  input  logic     mem_read_ex_i,
  input  reg_idx_t rt_ex_i,
  input  reg_idx_t rs_id_i,
  input  reg_idx_t rt_id_i,
  output logic     hazard_c
);

  // $zero is never a real dependency
  assign hazard_c = valid_id_i & mem_read_ex_i & (rt_ex_i != '0) &
                    ((rt_ex_i == rs_id_i) | (rt_ex_i == rt_id_i));

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage with IF/ID pipeline register: PC, fetch redirect, load-use stall and perf counters.
module if_id_stage
  import pipeline_pkg::*;
#(
  parameter word_t       RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rstN,
  if_id_stage_if.master     bus,
  output logic [CNT_W-1:0]  stallCount,
  output logic [CNT_W-1:0]  flushCount
);

  word_t            pc_q, pc_d, pc_next;
  if_id_t           ifid_q, ifid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             hazard;
  logic             redirect;
  word_t            target;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  hazard_detect u_hazard (
    .valid_id_i    (ifid_q.valid),
    .mem_read_ex_i (bus.memReadEX),
    .rt_ex_i       (bus.instructionRtEX),
    .rs_id_i       (rs_field(ifid_q.instr)),
    .rt_id_i       (rt_field(ifid_q.instr)),
    .hazard_c      (hazard)
  );

  // A stalled branch/jump stays in ID and is re-evaluated once the load has moved on
  assign redirect = (bus.branchTakenID | bus.jumpID) & ifid_q.valid & ~hazard;
  assign target   = bus.branchTakenID ? bus.branchTargetID : bus.jumpTargetID;
  assign pc_next  = pc_q + PC_STEP;

  always_comb begin
    pc_d        = pc_q;
    ifid_d      = ifid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!bus.hold) begin
      if (hazard) begin
        stall_cnt_d = sat_inc(stall_cnt_q);
      end else if (redirect) begin
        pc_d        = target;
        ifid_d      = '{instr: NOP_INSTR, pc_add4: '0, valid: 1'b0};
        flush_cnt_d = sat_inc(flush_cnt_q);
      end else begin
        pc_d   = pc_next;
        ifid_d = '{instr: bus.instructionIF, pc_add4: pc_next, valid: 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pc_q        <= RESET_PC;
      ifid_q      <= '{instr: NOP_INSTR, pc_add4: '0, valid: 1'b0};
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      ifid_q      <= ifid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pcIF          = pc_q;
  assign bus.pcAdd4ID      = ifid_q.pc_add4;
  assign bus.instructionID = ifid_q.instr;
  assign bus.validID       = ifid_q.valid;
  assign bus.idExFlush     = hazard & ~bus.hold;
  assign bus.idExStall     = bus.hold;
  assign stallCount        = stall_cnt_q;
  assign flushCount        = flush_cnt_q;

endmodule
